// File: rtl/ram8_burst.sv
// Eight-word register bank with random read/write port and a valid/ready burst reader.
// Optional sequential word clear is compiled in with RAM8_CLEAR_EN.

module Mux8way16 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] out
);
   always_comb begin
      unique case (sel)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         default: out = h;
      endcase
   end
endmodule

module ram8_burst #(
   parameter int          WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] IN,
   input  logic             LOAD,
   input  logic [2:0]       ADDRESS,
   output logic [WIDTH-1:0] OUT,
   input  logic             BURST_START,
   input  logic [2:0]       BURST_BASE,
   input  logic [3:0]       BURST_LEN,
   output logic [WIDTH-1:0] BURST_DATA,
   output logic             BURST_VALID,
   input  logic             BURST_READY,
   output logic             BURST_LAST,
`ifdef RAM8_CLEAR_EN
   input  logic             CLEAR,
`endif
   output logic             BUSY
);

`ifdef RAM8_CLEAR_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

   logic [WIDTH-1:0] mem [DEPTH];
   state_t           state, state_nxt;
   logic [2:0]       ptr, ptr_nxt;
   logic [3:0]       rem, rem_nxt;
   logic [3:0]       eff_len;
   logic [2:0]       rd_addr;
   logic             rd_en;
   logic             wr_en;
   logic             valid_nxt, last_nxt;
   logic [2:0]       clr_idx, clr_idx_nxt;
   logic             clr_en;

   assign eff_len = (BURST_LEN > 4'd8) ? 4'd8 : BURST_LEN;

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      rem_nxt     = rem;
      rd_en       = 1'b0;
      rd_addr     = ptr;
      wr_en       = LOAD;
      valid_nxt   = BURST_VALID;
      last_nxt    = BURST_LAST;
      clr_idx_nxt = clr_idx;
      clr_en      = 1'b0;
      unique case (state)
         S_IDLE: begin
`ifdef RAM8_CLEAR_EN
            if (CLEAR) begin
               state_nxt   = S_CLEAR;
               clr_idx_nxt = '0;
            end else
`endif
            if (BURST_START && BURST_LEN != '0) begin
               state_nxt = S_RUN;
               rd_en     = 1'b1;
               rd_addr   = BURST_BASE;
               ptr_nxt   = BURST_BASE + 3'd1;
               rem_nxt   = eff_len;
               valid_nxt = 1'b1;
               last_nxt  = (eff_len == 4'd1);
            end
         end
         S_RUN: begin
            if (BURST_VALID && BURST_READY) begin
               if (rem > 4'd1) begin
                  rd_en    = 1'b1;
                  ptr_nxt  = ptr + 3'd1;
                  rem_nxt  = rem - 4'd1;
                  last_nxt = (rem == 4'd2);
               end else begin
                  state_nxt = S_IDLE;
                  rem_nxt   = '0;
                  valid_nxt = 1'b0;
                  last_nxt  = 1'b0;
               end
            end
         end
`ifdef RAM8_CLEAR_EN
         S_CLEAR: begin
            wr_en       = 1'b0;
            clr_en      = 1'b1;
            clr_idx_nxt = clr_idx + 3'd1;
            if (clr_idx == 3'd7) state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         ptr         <= '0;
         rem         <= '0;
         clr_idx     <= '0;
         BURST_DATA  <= '0;
         BURST_VALID <= 1'b0;
         BURST_LAST  <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         rem         <= rem_nxt;
         clr_idx     <= clr_idx_nxt;
         BURST_VALID <= valid_nxt;
         BURST_LAST  <= last_nxt;
         BUSY        <= (state_nxt != S_IDLE);
         // Non-blocking read alongside the write below gives read-before-write.
         if (rd_en) BURST_DATA <= mem[rd_addr];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) mem[ADDRESS] <= IN;
         if (clr_en) mem[clr_idx] <= '0;
      end
   end

   Mux8way16 #(.WIDTH(WIDTH)) u_mux (
      .a   (mem[0]),
      .b   (mem[1]),
      .c   (mem[2]),
      .d   (mem[3]),
      .e   (mem[4]),
      .f   (mem[5]),
      .g   (mem[6]),
      .h   (mem[7]),
      .sel (ADDRESS),
      .out (OUT)
   );

endmodule

// File: tb/tb_ram8_burst.sv
// Self-checking bench for ram8_burst: vector table for random access, scoreboard for bursts.

module tb_ram8_burst;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] IN = '0;
   logic        LOAD = 1'b0;
   logic [2:0]  ADDRESS = '0;
   logic [15:0] OUT;
   logic        BURST_START = 1'b0;
   logic [2:0]  BURST_BASE = '0;
   logic [3:0]  BURST_LEN = '0;
   logic [15:0] BURST_DATA;
   logic        BURST_VALID;
   logic        BURST_READY = 1'b0;
   logic        BURST_LAST;
   logic        BUSY;
`ifdef RAM8_CLEAR_EN
   logic        CLEAR = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int xfers = 0;

   typedef struct packed {logic [15:0] data; logic last;} word_t;
   word_t sb[$];
   logic [15:0] model [8];

   typedef struct {
      logic        load;
      logic [2:0]  addr;
      logic [15:0] din;
      logic [15:0] exp_out;
   } vec_t;
   vec_t vecs [16];

   typedef struct {
      logic [2:0] base;
      logic [3:0] len;
      int         exp_n;
   } bvec_t;
   bvec_t bvecs [4];

   always #5 CLK = ~CLK;

   ram8_burst #(.WIDTH(16), .DEPTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .IN          (IN),
      .LOAD        (LOAD),
      .ADDRESS     (ADDRESS),
      .OUT         (OUT),
      .BURST_START (BURST_START),
      .BURST_BASE  (BURST_BASE),
      .BURST_LEN   (BURST_LEN),
      .BURST_DATA  (BURST_DATA),
      .BURST_VALID (BURST_VALID),
      .BURST_READY (BURST_READY),
      .BURST_LAST  (BURST_LAST),
`ifdef RAM8_CLEAR_EN
      .CLEAR       (CLEAR),
`endif
      .BUSY        (BUSY)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Transfers are observed mid-cycle, before the edge that completes them.
   always @(negedge CLK) begin
      if (!RST && BURST_VALID && BURST_READY) begin
         xfers++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer actual=%0h required=none", BURST_DATA);
         end else begin
            word_t w;
            w = sb.pop_front();
            chk("burst_data", 32'(BURST_DATA), 32'(w.data));
            chk("burst_last", 32'(BURST_LAST), 32'(w.last));
         end
      end
   end

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
      sb.delete();
      for (int k = 0; k < 8; k++) model[k] = '0;
   endtask

   task automatic start_burst(input logic [2:0] base, input logic [3:0] len);
      int n;
      n = (len > 4'd8) ? 8 : int'(len);
      for (int k = 0; k < n; k++)
         sb.push_back('{data: model[3'(int'(base) + k)], last: (k == n - 1)});
      BURST_BASE  = base;
      BURST_LEN   = len;
      BURST_START = 1'b1;
      step();
      BURST_START = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while (BUSY && t < budget) begin
         step();
         t++;
      end
      if (BUSY) begin
         checks++;
         errors++;
         $display("FAIL wait_idle actual=busy required=idle_within_%0d", budget);
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int x0;
      for (int k = 0; k < 8; k++) begin
         vecs[k]     = '{1'b1, 3'(k), 16'(1 << k), 16'(1 << k)};
         vecs[k + 8] = '{1'b0, 3'(k), 16'h0000, 16'(1 << k)};
      end
      bvecs[0] = '{3'd0, 4'd8,  8};
      bvecs[1] = '{3'd0, 4'd0,  0};
      bvecs[2] = '{3'd3, 4'd15, 8};
      bvecs[3] = '{3'd5, 4'd1,  1};

      step(2);
      do_reset();
      chk("rst_busy",  32'(BUSY), 32'd0);
      chk("rst_valid", 32'(BURST_VALID), 32'd0);
      chk("rst_last",  32'(BURST_LAST), 32'd0);
      chk("rst_data",  32'(BURST_DATA), 32'd0);

      foreach (vecs[i]) begin
         LOAD    = vecs[i].load;
         ADDRESS = vecs[i].addr;
         IN      = vecs[i].din;
         #1;
         if (vecs[i].load) chk("out_before_write", 32'(OUT), 32'(model[vecs[i].addr]));
         step();
         if (vecs[i].load) model[vecs[i].addr] = vecs[i].din;
         LOAD = 1'b0;
         #1;
         chk("out_read", 32'(OUT), 32'(vecs[i].exp_out));
      end

      BURST_READY = 1'b1;
      foreach (bvecs[i]) begin
         x0 = xfers;
         start_burst(bvecs[i].base, bvecs[i].len);
         chk("valid_after_start", 32'(BURST_VALID), 32'(bvecs[i].exp_n != 0));
         chk("busy_after_start",  32'(BUSY),        32'(bvecs[i].exp_n != 0));
         if (bvecs[i].exp_n > 0) begin
            step(bvecs[i].exp_n - 1);
            chk("busy_on_last", 32'(BUSY), 32'd1);
            chk("last_on_last", 32'(BURST_LAST), 32'd1);
            step();
            chk("busy_after_last",  32'(BUSY), 32'd0);
            chk("valid_after_last", 32'(BURST_VALID), 32'd0);
         end
         wait_idle(20);
         chk("xfer_count", 32'(xfers - x0), 32'(bvecs[i].exp_n));
      end

      // Wrap with stalls and a write to the presented word.
      x0 = xfers;
      BURST_READY = 1'b0;
      start_burst(3'd6, 4'd4);
      chk("wrap_first", 32'(BURST_DATA), 32'h0040);
      BURST_READY = 1'b1;
      step();
      BURST_READY = 1'b0;
      LOAD = 1'b1;
      ADDRESS = 3'd7;
      IN = 16'hFFFF;
      step();
      model[7] = 16'hFFFF;
      LOAD = 1'b0;
      chk("stall_data_write", 32'(BURST_DATA), 32'h0080);
      step();
      chk("stall_data_hold",  32'(BURST_DATA), 32'h0080);
      chk("stall_valid_hold", 32'(BURST_VALID), 32'd1);
      for (int k = 0; k < 9 && BUSY; k++) begin
         BURST_READY = (k % 3 == 0);
         step();
      end
      BURST_READY = 1'b1;
      wait_idle(10);
      chk("wrap_xfers", 32'(xfers - x0), 32'd4);
      ADDRESS = 3'd7;
      #1;
      chk("write_in_stall", 32'(OUT), 32'hFFFF);

      // Start while busy is ignored.
      x0 = xfers;
      BURST_READY = 1'b0;
      start_burst(3'd0, 4'd8);
      BURST_BASE = 3'd4;
      BURST_LEN = 4'd2;
      BURST_START = 1'b1;
      step();
      BURST_START = 1'b0;
      chk("busy_start_data", 32'(BURST_DATA), 32'(model[0]));
      BURST_READY = 1'b1;
      wait_idle(20);
      chk("busy_start_xfers", 32'(xfers - x0), 32'd8);

      // Reset after three of eight words.
      x0 = xfers;
      start_burst(3'd0, 4'd8);
      step(3);
      chk("pre_reset_xfers", 32'(xfers - x0), 32'd3);
      do_reset();
      chk("abort_valid", 32'(BURST_VALID), 32'd0);
      chk("abort_busy",  32'(BUSY), 32'd0);
      for (int a = 0; a < 8; a++) begin
         ADDRESS = 3'(a);
         #1;
         chk("abort_out_zero", 32'(OUT), 32'd0);
      end
      x0 = xfers;
      start_burst(3'd2, 4'd3);
      wait_idle(10);
      chk("post_reset_xfers", 32'(xfers - x0), 32'd3);

`ifdef RAM8_CLEAR_EN
      for (int k = 0; k < 8; k++) begin
         LOAD = 1'b1;
         ADDRESS = 3'(k);
         IN = 16'(16'h0100 + k);
         step();
         model[k] = IN;
      end
      LOAD = 1'b0;
      CLEAR = 1'b1;
      step();
      CLEAR = 1'b0;
      LOAD = 1'b1;
      ADDRESS = 3'd3;
      IN = 16'hBEEF;
      for (int k = 0; k < 7; k++) begin
         chk("clear_busy", 32'(BUSY), 32'd1);
         step();
      end
      chk("clear_busy", 32'(BUSY), 32'd1);
      step();
      LOAD = 1'b0;
      chk("clear_done", 32'(BUSY), 32'd0);
      for (int a = 0; a < 8; a++) begin
         ADDRESS = 3'(a);
         #1;
         chk("clear_out_zero", 32'(OUT), 32'd0);
      end
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
